// File: rtl/pacote_rv32m.sv
// Shared RV32M definitions: operand width, funct3 encodings and mul/div FSM states.
package pacote_rv32m;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef logic [1:0] estado_t;
  localparam estado_t OCIOSO  = 2'd0;
  localparam estado_t CALCULA = 2'd1;
  localparam estado_t AJUSTE  = 2'd2;

  // Magnitude of a possibly signed operand; 0x80000000 stays 0x80000000 read as unsigned.
  function automatic logic [XLEN-1:0] modulo(input logic [XLEN-1:0] v, input logic com_sinal);
    return (com_sinal && v[XLEN-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/passo_mul_div.sv
// One combinational iteration: MSB-first shift/add multiply or restoring divide step.
module passo_mul_div #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   oper,
  input  logic           bit_in,
  output logic [2*W-1:0] acc_prox
);
  logic [W:0]     r_desl;
  logic           cabe;
  logic [W-1:0]   dif;
  logic [2*W-1:0] soma;

  always_comb begin
    r_desl = {acc[2*W-1:W], bit_in};
    cabe   = r_desl >= {1'b0, oper};
    dif    = r_desl[W-1:0] - oper;
    soma   = {acc[2*W-2:0], 1'b0} + (bit_in ? {{W{1'b0}}, oper} : {2*W{1'b0}});
    // Divide: high half is the partial remainder, low half collects quotient bits.
    if (is_div)
      acc_prox = cabe ? {dif, acc[W-2:0], 1'b1} : {r_desl[W-1:0], acc[W-2:0], 1'b0};
    else
      acc_prox = soma;
  end
endmodule

// File: rtl/unidade_mul_div.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, one operation in flight.
// Optional DIV_ATALHO_EN: divide-by-zero and signed overflow skip the iteration.
module unidade_mul_div #(
  parameter int XLEN   = 32,
  parameter int CICLOS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inicio,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ocupado,
  output logic            pronto,
  output logic [XLEN-1:0] resultado
);
  import pacote_rv32m::*;

  localparam int CW = $clog2(CICLOS);

  estado_t          estado;
  logic [2:0]       f3;
  logic [XLEN-1:0]  oper, desloc;
  logic [2*XLEN-1:0] acc, acc_prox, prod;
  logic [XLEN-1:0]  quo, rem, saida;
  logic             neg_p, neg_r;
  logic [CW-1:0]    cnt;
  logic             s_a, s_b, sa, sb, div_in;
  logic [XLEN-1:0]  mag_a, mag_b;
`ifdef DIV_ATALHO_EN
  logic             atalho;
  logic             ovf;
`endif

  always_comb begin
    div_in = funct3[2];
    s_a    = (funct3 == F3_DIV) || (funct3 == F3_REM) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
    s_b    = (funct3 == F3_DIV) || (funct3 == F3_REM) || (funct3 == F3_MULH);
    sa     = s_a && a[XLEN-1];
    sb     = s_b && b[XLEN-1];
    mag_a  = modulo(a, s_a);
    mag_b  = modulo(b, s_b);
  end

`ifdef DIV_ATALHO_EN
  assign ovf = s_b && div_in && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
`endif

  passo_mul_div #(.W(XLEN)) u_passo (
    .is_div  (f3[2]),
    .acc     (acc),
    .oper    (oper),
    .bit_in  (desloc[XLEN-1]),
    .acc_prox(acc_prox)
  );

  always_comb begin
    prod = neg_p ? -acc : acc;
    quo  = neg_p ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3)
      F3_MUL:                       saida = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: saida = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              saida = quo;
      default:                      saida = rem;
    endcase
  end

  assign ocupado = (estado != OCIOSO);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= OCIOSO;
      f3        <= '0;
      oper      <= '0;
      desloc    <= '0;
      acc       <= '0;
      neg_p     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
      pronto    <= 1'b0;
      resultado <= '0;
`ifdef DIV_ATALHO_EN
      atalho    <= 1'b0;
`endif
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: if (inicio) begin
          f3     <= funct3;
          oper   <= div_in ? mag_b : mag_a;
          desloc <= div_in ? mag_a : mag_b;
          acc    <= '0;
          cnt    <= '0;
          // A zero divisor keeps the all-ones quotient unsigned regardless of dividend sign.
          neg_p  <= div_in ? ((sa ^ sb) && (b != '0)) : (sa ^ sb);
          neg_r  <= sa;
          estado <= CALCULA;
`ifdef DIV_ATALHO_EN
          if (div_in && ((b == '0) || ovf)) begin
            acc    <= (b == '0) ? {mag_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            atalho <= 1'b1;
            estado <= AJUSTE;
          end
`endif
        end
        CALCULA: begin
          acc    <= acc_prox;
          desloc <= desloc << 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(CICLOS-1)) estado <= AJUSTE;
        end
        AJUSTE: begin
`ifdef DIV_ATALHO_EN
          // Shortcut path waits one cycle here so the stall sees a 2-cycle latency.
          if (atalho) begin
            atalho <= 1'b0;
          end else begin
            resultado <= saida;
            pronto    <= 1'b1;
            estado    <= OCIOSO;
          end
`else
          resultado <= saida;
          pronto    <= 1'b1;
          estado    <= OCIOSO;
`endif
        end
        default: estado <= OCIOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_unidade_mul_div.sv
// Self-checking bench for unidade_mul_div: vector table plus busy/reset/back-to-back sequences.
module tb_unidade_mul_div;
  import pacote_rv32m::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        ocupado, pronto;
  logic [31:0] resultado;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] esp;
    logic        curto;
  } vet_t;

  vet_t tab[16];

  unidade_mul_div dut (
    .clk      (clk),
    .rst      (rst),
    .inicio   (inicio),
    .funct3   (funct3),
    .a        (a),
    .b        (b),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .resultado(resultado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] esp);
    total++;
    if (act !== esp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, esp);
    end
  endtask

  // Called at a negedge; returns #1 after the accept edge with the inputs scrambled.
  task automatic iniciar(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    funct3 = f; a = x; b = y; inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
  endtask

  // lat = clock edges from the accept edge to the one that raised pronto (0 = timeout).
  task automatic esperar(output int lat, output logic sempre_ocupado);
    lat = 0;
    sempre_ocupado = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (pronto) begin
        lat = i - 1;
        break;
      end
      if (!ocupado) sempre_ocupado = 1'b0;
    end
  endtask

  function automatic int lat_esp(input logic curto);
`ifdef DIV_ATALHO_EN
    return curto ? 2 : 33;
`else
    return curto ? 33 : 33;
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic busy;
    int   n_pronto;

    tab[0]  = '{F3_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    tab[1]  = '{F3_MULH,   32'h80000000,  32'h80000000, 32'h40000000, 1'b0};
    tab[2]  = '{F3_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    tab[3]  = '{F3_MULHSU, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 1'b0};
    tab[4]  = '{F3_DIVU,   32'd100,       32'd7,        32'd14,       1'b0};
    tab[5]  = '{F3_REMU,   32'd100,       32'd7,        32'd2,        1'b0};
    tab[6]  = '{F3_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0};
    tab[7]  = '{F3_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0};
    tab[8]  = '{F3_DIV,    32'd5,         32'd0,        32'hFFFFFFFF, 1'b1};
    tab[9]  = '{F3_REM,    32'd5,         32'd0,        32'd5,        1'b1};
    tab[10] = '{F3_DIVU,   32'd5,         32'd0,        32'hFFFFFFFF, 1'b1};
    tab[11] = '{F3_REMU,   32'd5,         32'd0,        32'd5,        1'b1};
    tab[12] = '{F3_DIV,    32'hFFFFFFFB,  32'd0,        32'hFFFFFFFF, 1'b1};
    tab[13] = '{F3_REM,    32'hFFFFFFFB,  32'd0,        32'hFFFFFFFB, 1'b1};
    tab[14] = '{F3_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1};
    tab[15] = '{F3_REM,    32'h80000000,  32'hFFFFFFFF, 32'd0,        1'b1};

    rst = 1'b1; inicio = 1'b1; funct3 = F3_MUL; a = 32'd3; b = 32'd4;
    @(negedge clk);
    @(negedge clk);
    chk("reset ocupado", {31'b0, ocupado}, 32'd0);
    chk("reset pronto", {31'b0, pronto}, 32'd0);
    chk("reset resultado", resultado, 32'd0);
    rst = 1'b0; inicio = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      iniciar(tab[i].f3, tab[i].a, tab[i].b);
      esperar(lat, busy);
      chk($sformatf("v%0d resultado", i), resultado, tab[i].esp);
      chk($sformatf("v%0d latencia", i), 32'(lat), 32'(lat_esp(tab[i].curto)));
      chk($sformatf("v%0d ocupado durante", i), {31'b0, busy}, 32'd1);
      chk($sformatf("v%0d ocupado no pronto", i), {31'b0, ocupado}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d pulso pronto", i), {31'b0, pronto}, 32'd0);
      chk($sformatf("v%0d resultado retido", i), resultado, tab[i].esp);
    end

    // Start pulse while busy must be ignored.
    iniciar(F3_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    inicio = 1'b1; funct3 = F3_MUL; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    inicio = 1'b0;
    esperar(lat, busy);
    chk("ignora resultado", resultado, 32'd14);
    chk("ignora latencia", 32'(lat), 32'd23);

    // Reset mid-operation aborts with no pronto.
    iniciar(F3_DIVU, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort ocupado", {31'b0, ocupado}, 32'd0);
    chk("abort pronto", {31'b0, pronto}, 32'd0);
    chk("abort resultado", resultado, 32'd0);
    n_pronto = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pronto) n_pronto++;
    end
    chk("abort sem pronto", 32'(n_pronto), 32'd0);

    // Back-to-back: start accepted in the pronto cycle.
    iniciar(F3_DIVU, 32'd100, 32'd7);
    esperar(lat, busy);
    chk("b2b primeiro", resultado, 32'd14);
    iniciar(F3_MUL, 32'd3, 32'd4);
    esperar(lat, busy);
    chk("b2b segundo", resultado, 32'd12);
    chk("b2b latencia", 32'(lat), 32'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unidade_mul_div.md
Name: unidade_mul_div

Overview:
- Iterative RV32M multiply/divide unit directly downstream of the register bank.
- Consumes the two register read operands (d1, d2 from the bank) and produces a 32-bit result for writeback into the bank.
- Shares the integer execute stage with the ALU: decode steers M-extension instructions here and stalls until pronto.
- One operation in flight; a single-bit-per-cycle shift/add or shift/subtract datapath.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CICLOS, XLEN, number of iteration cycles; fixed equal to XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- inicio  input  1  start request; sampled only when ocupado=0.
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand (bank d1).
- b  input  XLEN  rs2 operand (bank d2).
- ocupado  output  1  busy, operation in progress.
- pronto  output  1  one-cycle pulse: resultado is valid.
- resultado  output  XLEN  result; held until the next accepted start.

Behaviour:
- Reset, evaluated at clk edge with rst=1:
  - state=OCIOSO; ocupado=0, pronto=0, resultado=0.
  - All internal registers cleared.
  - rst overrides inicio in the same cycle.
- States: OCIOSO -> CALCULA -> AJUSTE -> OCIOSO.
- OCIOSO, edge with inicio=1 (accept edge E0):
  - Latch funct3.
  - Latch absolute values of a and b for signed operands: DIV/REM both signed; MULH both signed; MULHSU a signed, b unsigned.
  - Latch result sign flags; clear the 64-bit accumulator/remainder; counter=0.
  - ocupado=1 after E0; go to CALCULA.
- CALCULA, edges E1..E32, one bit per edge; counter increments and leaves the state at counter=31.
  - Multiply: shift-add into the 64-bit product.
  - Divide: restoring step on a 64-bit remainder/quotient pair.
- AJUSTE, edge E33:
  - Apply sign correction: two's-complement negate of the 64-bit product, quotient, or remainder when required. Remainder takes the dividend's sign.
  - Select output: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
  - Write resultado; pronto=1 for exactly the cycle after E33; ocupado=0 after E33; return to OCIOSO.
- Latency: pronto visible 33 cycles after the accept edge. Back-to-back starts are allowed: inicio may be high in the pronto cycle and is accepted.
- inicio while ocupado=1: ignored; operands are not re-latched.
- a/b/funct3 may change after E0 without effect.
- Divide by zero, default build: runs the full iteration. Required results: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU = a.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV=0x80000000, REM=0.
- Both cases must come out of the normal datapath plus AJUSTE without extra traps; no exceptions are raised.
- rst mid-operation: aborts immediately, no pronto, resultado=0.
- Unsigned abs of 0x80000000 is 0x80000000; internal paths are 33/64 bits wide, so there is no overflow.

Optional Feature:
- Macro DIV_ATALHO_EN.
- When defined, in OCIOSO on accept:
  - If the operation is a divide and b==0, or it is signed overflow, skip CALCULA and go straight to AJUSTE with the special result preloaded.
  - pronto is visible 2 cycles after the accept edge, with the same values as the default build.
- When undefined: all operations take exactly 33 cycles, giving a fixed latency for the pipeline stall logic.

Decomposition:
- Shared package pacote_rv32m:
  - funct3 encodings as named constants (F3_MUL..F3_REMU).
  - State enum (OCIOSO, CALCULA, AJUSTE).
  - XLEN constant, also reused by the register bank and ALU.
- One natural sub-module, passo_mul_div:
  - Purely combinational single-iteration step: next accumulator/remainder from current state, divisor/multiplicand, and an is_div select.
  - The top level holds the FSM, counter, sign handling and output register.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> resultado=0xFFFFFFEB; pronto exactly 33 cycles after accept; ocupado high throughout.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14. REMU -> 2. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
- DIV a=5, b=0 -> 0xFFFFFFFF; REM -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Checked with and without DIV_ATALHO_EN (latency 2 vs 33).
- Start DIVU 100/7, pulse inicio with new operands at cycle 10 -> ignored, result still 14. Assert rst at cycle 20 -> ocupado=0, no pronto, resultado=0.
- Back-to-back: inicio held high in the pronto cycle with MUL 3*4 -> second accept; 12 after a further 33 cycles.
